// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared state encoding and fetch constants
package instruction_fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_KILL} state_e;
  localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter plus the address of a read being killed by a redirect
module ifu_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        inc,
  input  logic        save_kill,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] kill_addr
);
  logic [31:0] pc_q, pc_d, kill_q, kill_d;
  always_comb begin
    pc_d   = load ? (target & ~32'd3) : inc ? pc_q + PC_INCR : pc_q;
    kill_d = save_kill ? pc_q : kill_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_VECTOR;
      kill_q <= RESET_VECTOR;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
    end
  end
  assign pc        = pc_q;
  assign kill_addr = kill_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage FSM and output mux; IFU_PERF_CNT_EN adds fetch/stall counters
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_PLUS_4,
  output logic [31:0] PC_DIRECT,
`ifdef IFU_PERF_CNT_EN
  output logic        FETCH_BUSYWAIT,
  output logic [31:0] PERF_FETCHED,
  output logic [31:0] PERF_STALLED
`else
  output logic        FETCH_BUSYWAIT
`endif
);
  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d, pc, kill_addr;
  logic        load, inc, save_kill;

  ifu_pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
    .clk(CLK), .rst_n(RESET), .load(load), .inc(inc), .save_kill(save_kill),
    .target(BRANCH_TARGET), .pc(pc), .kill_addr(kill_addr)
  );

  assign PC_DIRECT = pc;
  assign PC_PLUS_4 = pc + PC_INCR;

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    load           = 1'b0;
    inc            = 1'b0;
    save_kill      = 1'b0;
    IMEM_READ      = 1'b0;
    IMEM_ADDRESS   = pc;
    INSTRUCTION    = NOP_INSTR;
    FETCH_BUSYWAIT = 1'b1;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        load    = BRANCH_TAKEN;
      end
      S_FETCH: begin
        IMEM_READ = 1'b1;
        if (IMEM_BUSYWAIT) begin
          load      = BRANCH_TAKEN;
          save_kill = BRANCH_TAKEN;
          state_d   = BRANCH_TAKEN ? S_KILL : S_FETCH;
        end else if (BRANCH_TAKEN) begin
          FETCH_BUSYWAIT = 1'b0;
          load           = 1'b1;
        end else if (STALL) begin
          INSTRUCTION = IMEM_READDATA;
          hold_d      = IMEM_READDATA;
          state_d     = S_HOLD;
        end else begin
          INSTRUCTION    = IMEM_READDATA;
          FETCH_BUSYWAIT = 1'b0;
          inc            = 1'b1;
        end
      end
      S_HOLD: begin
        INSTRUCTION    = BRANCH_TAKEN ? NOP_INSTR : hold_q;
        FETCH_BUSYWAIT = STALL && !BRANCH_TAKEN;
        load           = BRANCH_TAKEN;
        inc            = !BRANCH_TAKEN && !STALL;
        state_d        = (BRANCH_TAKEN || !STALL) ? S_FETCH : S_HOLD;
      end
      S_KILL: begin
        // the stale read must finish on its original address before the new PC is issued
        IMEM_READ    = 1'b1;
        IMEM_ADDRESS = kill_addr;
        load         = BRANCH_TAKEN;
        state_d      = IMEM_BUSYWAIT ? S_KILL : S_FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, stalled_q, stalled_d;
  always_comb begin
    fetched_d = fetched_q + {31'd0, !FETCH_BUSYWAIT && (INSTRUCTION != NOP_INSTR)};
    stalled_d = stalled_q + {31'd0, FETCH_BUSYWAIT && (state_q != S_IDLE)};
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fetched_q <= '0;
      stalled_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stalled_q <= stalled_d;
    end
  end
  assign PERF_FETCHED = fetched_q;
  assign PERF_STALLED = stalled_q;
`endif
endmodule
